// File: rtl/alu_result_engine.sv
// Multi-cycle ALU with a valid/ready request port and a one-cycle done pulse.
// add/and/xor take one execute cycle, mul takes W execute cycles (shift-add).
module alu_result_engine #(
   parameter int ALU_IN_OP_WIDTH      = 8,
   parameter int ALU_OUT_RESULT_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            valid,
   input  logic [2:0]                      op,
   input  logic [ALU_IN_OP_WIDTH-1:0]      a,
   input  logic [ALU_IN_OP_WIDTH-1:0]      b,
   output logic                            ready,
   output logic                            done,
   output logic [ALU_OUT_RESULT_WIDTH-1:0] result,
   output logic [1:0]                      o_dbg_state
);

   localparam int W  = ALU_IN_OP_WIDTH;
   localparam int RW = ALU_OUT_RESULT_WIDTH;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   generate
      if (RW != 2 * W) begin : g_width_check
         $fatal(1, "ALU_OUT_RESULT_WIDTH must equal 2*ALU_IN_OP_WIDTH");
      end
   endgenerate

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_RST = 3'b111;

   // Handshake: a request transfers on a rising edge where valid && ready.
   // ready is high only in IDLE; anything presented while busy is dropped.

   logic [1:0]    r_state;
   logic [2:0]    r_op;
   logic [RW-1:0] r_mcand;   // operand a, shifted left each mul step
   logic [W-1:0]  r_mplier;  // operand b, shifted right each mul step
   logic [RW-1:0] r_acc;
   logic [CW-1:0] r_cnt;
   logic [RW-1:0] r_result;

   logic          w_accept;
   logic          w_exec_last;
   logic [RW-1:0] w_b_ext;
   logic [RW-1:0] w_acc_step;
   logic [RW-1:0] w_exec_result;

   always_comb begin
      w_accept      = valid && (r_state == S_IDLE);
      w_b_ext       = {{W{1'b0}}, r_mplier};
      w_acc_step    = r_acc + (r_mplier[0] ? r_mcand : '0);
      w_exec_last   = (r_op != OP_MUL) || (r_cnt == CW'(W - 1));
      w_exec_result = '0;
      case (r_op)
         OP_ADD:  w_exec_result = r_mcand + w_b_ext;
         OP_AND:  w_exec_result = r_mcand & w_b_ext;
         OP_XOR:  w_exec_result = r_mcand ^ w_b_ext;
         OP_MUL:  w_exec_result = w_acc_step;
         default: w_exec_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_op     <= 3'b000;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  case (op)
                     OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
                        r_op     <= op;
                        r_mcand  <= {{W{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_EXEC;
                     end
                     OP_RST:  r_result <= '0;
                     default: ;
                  endcase
               end
            end
            S_EXEC: begin
               // Only the finished value reaches result; partials stay in r_acc.
               if (w_exec_last) begin
                  r_result <= w_exec_result;
                  r_state  <= S_DONE;
               end else begin
                  r_acc    <= w_acc_step;
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_cnt    <= r_cnt + CW'(1);
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ready       = (r_state == S_IDLE);
   assign done        = (r_state == S_DONE);
   assign result      = r_result;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_result_engine.sv
// Self-checking bench for alu_result_engine: directed scenarios plus random
// operations checked against an arithmetic reference model.
module tb_alu_result_engine;

   localparam int W  = 8;
   localparam int RW = 16;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_RST = 3'b111;

   logic          clk;
   logic          rst;
   logic          valid;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          ready;
   logic          done;
   logic [RW-1:0] result;
   logic [1:0]    dbg_state;

   int n_cmp;
   int n_bad;
   logic [RW-1:0] exp_result;

   alu_result_engine #(
      .ALU_IN_OP_WIDTH     (W),
      .ALU_OUT_RESULT_WIDTH(RW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .valid      (valid),
      .op         (op),
      .a          (a),
      .b          (b),
      .ready      (ready),
      .done       (done),
      .result     (result),
      .o_dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge: start of the next cycle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [RW-1:0] model_calc(input logic [2:0] m_op,
                                                input logic [W-1:0] m_a,
                                                input logic [W-1:0] m_b);
      int x;
      logic [RW-1:0] r;
      case (m_op)
         OP_ADD:  x = int'(m_a) + int'(m_b);
         OP_AND:  x = int'(m_a & m_b);
         OP_XOR:  x = int'(m_a ^ m_b);
         OP_MUL:  x = int'(m_a) * int'(m_b);
         default: x = 0;
      endcase
      r = x[RW-1:0];
      return r;
   endfunction

   function automatic bit is_exec_op(input logic [2:0] m_op);
      return (m_op == OP_ADD) || (m_op == OP_AND) || (m_op == OP_XOR) || (m_op == OP_MUL);
   endfunction

   function automatic int model_latency(input logic [2:0] m_op);
      return (m_op == OP_MUL) ? W + 1 : 2;
   endfunction

   // ---------------- driver ----------------
   // Present one request in the current cycle (ready expected high), then
   // scramble the inputs while busy and check each cycle up to ready returning.
   task automatic do_op(input logic [2:0] t_op, input logic [W-1:0] t_a,
                        input logic [W-1:0] t_b, input string tag);
      int lat;
      logic [RW-1:0] new_res;
      n_cmp++;
      if (ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s ready_before_req: got %b want 1", tag, ready);
      end
      valid = 1'b1; op = t_op; a = t_a; b = t_b;
      step();
      valid = 1'($urandom_range(0, 1)); op = 3'($urandom_range(0, 7));
      a = 8'($urandom); b = 8'($urandom);
      if (is_exec_op(t_op)) begin
         lat = model_latency(t_op);
         new_res = model_calc(t_op, t_a, t_b);
         for (int k = 1; k <= lat; k++) begin
            n_cmp++;
            if (done !== (k == lat)) begin
               n_bad++;
               $display("FAIL %s done_c%0d: got %b want %b", tag, k, done, (k == lat));
            end
            n_cmp++;
            if (ready !== 1'b0) begin
               n_bad++;
               $display("FAIL %s ready_busy_c%0d: got %b want 0", tag, k, ready);
            end
            n_cmp++;
            if (result !== ((k == lat) ? new_res : exp_result)) begin
               n_bad++;
               $display("FAIL %s result_c%0d: got %h want %h", tag, k, result,
                        (k == lat) ? new_res : exp_result);
            end
            step();
            valid = 1'($urandom_range(0, 1)); op = 3'($urandom_range(0, 7));
            a = 8'($urandom); b = 8'($urandom);
         end
         exp_result = new_res;
         valid = 1'b0;
         n_cmp++;
         if (ready !== 1'b1 || done !== 1'b0 || result !== exp_result) begin
            n_bad++;
            $display("FAIL %s after_done: got ready=%b done=%b result=%h want 1 0 %h",
                     tag, ready, done, result, exp_result);
         end
      end else begin
         valid = 1'b0;
         if (t_op == OP_RST) exp_result = '0;
         n_cmp++;
         if (ready !== 1'b1 || done !== 1'b0 || result !== exp_result) begin
            n_bad++;
            $display("FAIL %s idle_op_c1: got ready=%b done=%b result=%h want 1 0 %h",
                     tag, ready, done, result, exp_result);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; valid = 1'b1; op = OP_ADD; a = 8'h11; b = 8'h22;
      step();
      step();
      n_cmp++;
      if (ready !== 1'b1 || done !== 1'b0 || result !== 16'h0000) begin
         n_bad++;
         $display("FAIL reset_state: got ready=%b done=%b result=%h want 1 0 0000",
                  ready, done, result);
      end
      exp_result = '0;
      rst = 1'b0; valid = 1'b0;
   endtask

   task automatic test_add_carry();
      do_op(OP_ADD, 8'hFF, 8'h01, "add_carry");
   endtask

   task automatic test_mul_max();
      do_op(OP_MUL, 8'hFF, 8'hFF, "mul_max");
   endtask

   task automatic test_back_to_back();
      do_op(OP_XOR, 8'hA5, 8'h0F, "b2b_xor");
      do_op(OP_AND, 8'hF0, 8'h3C, "b2b_and");
   endtask

   task automatic test_rst_during_mul();
      valid = 1'b1; op = OP_MUL; a = 8'h12; b = 8'h34;
      step();
      valid = 1'b0;
      for (int k = 1; k < 4; k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_result = '0;
      n_cmp++;
      if (ready !== 1'b1 || done !== 1'b0 || result !== 16'h0000) begin
         n_bad++;
         $display("FAIL rst_mid_mul: got ready=%b done=%b result=%h want 1 0 0000",
                  ready, done, result);
      end
      do_op(OP_ADD, 8'h03, 8'h04, "add_after_rst");
      n_cmp++;
      if (result !== 16'h0007) begin
         n_bad++;
         $display("FAIL add_after_rst_value: got %h want 0007", result);
      end
   endtask

   task automatic test_busy_ignored();
      valid = 1'b1; op = OP_MUL; a = 8'h02; b = 8'h03;
      step();
      op = OP_ADD; a = 8'h01; b = 8'h01;
      for (int k = 1; k <= W + 1; k++) begin
         n_cmp++;
         if (done !== (k == W + 1) || ready !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_c%0d: got done=%b ready=%b want %b 0", k, done, ready, (k == W + 1));
         end
         n_cmp++;
         if (result !== ((k == W + 1) ? 16'h0006 : exp_result)) begin
            n_bad++;
            $display("FAIL busy_result_c%0d: got %h want %h", k, result,
                     (k == W + 1) ? 16'h0006 : exp_result);
         end
         step();
      end
      exp_result = 16'h0006;
      n_cmp++;
      if (ready !== 1'b1 || result !== 16'h0006) begin
         n_bad++;
         $display("FAIL busy_ready_back: got ready=%b result=%h want 1 0006", ready, result);
      end
      step();
      valid = 1'b0;
      n_cmp++;
      if (ready !== 1'b0) begin
         n_bad++;
         $display("FAIL held_req_accept: got ready=%b want 0", ready);
      end
      step();
      n_cmp++;
      if (done !== 1'b1 || result !== 16'h0002) begin
         n_bad++;
         $display("FAIL held_req_done: got done=%b result=%h want 1 0002", done, result);
      end
      exp_result = 16'h0002;
      step();
   endtask

   task automatic test_rst_op_noop();
      do_op(OP_ADD, 8'hFF, 8'h01, "pre_rstop");
      do_op(OP_RST, 8'h55, 8'hAA, "rst_op");
      do_op(OP_ADD, 8'h40, 8'h02, "pre_noop");
      do_op(OP_NOP, 8'h12, 8'h34, "noop_000");
      do_op(3'b101, 8'h56, 8'h78, "noop_101");
      do_op(3'b110, 8'h9A, 8'hBC, "noop_110");
      step();
      n_cmp++;
      if (done !== 1'b0 || ready !== 1'b1 || result !== 16'h0042) begin
         n_bad++;
         $display("FAIL noop_quiet: got done=%b ready=%b result=%h want 0 1 0042",
                  done, ready, result);
      end
   endtask

   task automatic test_random();
      logic [2:0] r_op;
      logic [W-1:0] r_a;
      logic [W-1:0] r_b;
      for (int i = 0; i < 60; i++) begin
         r_op = 3'($urandom_range(0, 7));
         r_a  = 8'($urandom);
         r_b  = 8'($urandom);
         do_op(r_op, r_a, r_b, "random");
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      exp_result = '0;
      rst = 1'b1; valid = 1'b0; op = OP_NOP; a = '0; b = '0;
      test_reset();
      test_add_carry();
      test_mul_max();
      test_back_to_back();
      test_rst_during_mul();
      test_busy_ignored();
      test_rst_op_noop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
